alu_op_issuer: RTL and testbench
================================

ALU_OP_ISSUER -- requirements
Module: alu_op_issuer

Interface
REQ-001 SHALL have parameter WIDTH, default 16: data width of operands and result.
REQ-002 SHALL have parameter LATENCY, default 2, legal range 1..7: cycles the ALU bus is held before the result is sampled.
REQ-003 SHALL have CLK, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have RESET, input, 1: synchronous, active-high reset.
REQ-005 SHALL have CMD_VALID, input, 1: a command is offered.
REQ-006 SHALL have CMD_READY, output, 1: the block accepts a command this cycle.
REQ-007 SHALL have CMD_OP, input, 3: opcode (000 ADD, 001 SUB, 010 SRA, 011 SRL, 100 SLL, 101 AND, 110 OR, 111 illegal).
REQ-008 SHALL have CMD_A and CMD_B, inputs, WIDTH each: the operands.
REQ-009 SHALL have OP, output, 3: registered opcode driven to the ALU control decoder.
REQ-010 SHALL have A and B, outputs, WIDTH each: registered operands driven to the ALU.
REQ-011 SHALL have R, input, WIDTH: the ALU's combinational result.
REQ-012 SHALL have RES_VALID, output, 1: a result is presented.
REQ-013 SHALL have RES_READY, input, 1: the consumer takes the result.
REQ-014 SHALL have RES_DATA, output, WIDTH: the captured result.
REQ-015 SHALL have RES_OP, output, 3: the opcode that produced RES_DATA.
REQ-016 SHALL have RES_ERR, output, 1: the result is from an illegal opcode.
REQ-017 SHALL have OP_COUNT, output, 8: count of completed result handshakes.

Function
REQ-018 SHALL implement an FSM with states IDLE, ISSUE and DONE.
REQ-019 IDLE: CMD_READY=1; a command is accepted on an edge where CMD_VALID=1.
REQ-020 On accepting a legal opcode, SHALL load OP/A/B from CMD_OP/CMD_A/CMD_B, load the settle counter with LATENCY, and enter ISSUE.
REQ-021 ISSUE: CMD_READY=0, and OP/A/B SHALL be held constant.
REQ-022 ISSUE: the counter SHALL decrement each cycle; on the edge where the counter equals 1, SHALL capture R into RES_DATA and OP into RES_OP, clear RES_ERR, and enter DONE.
REQ-023 RES_VALID SHALL first be high exactly LATENCY cycles after the accept edge.
REQ-024 On accepting opcode 111, SHALL leave OP/A/B unchanged, set RES_DATA=0, RES_OP=111 and RES_ERR=1, and enter DONE on the next edge (1-cycle latency).
REQ-025 DONE: RES_VALID=1; RES_DATA, RES_OP and RES_ERR SHALL be stable while RES_READY=0.
REQ-026 DONE: CMD_READY SHALL equal RES_READY (a combinational path is permitted).
REQ-027 In DONE, an edge with RES_READY=1 completes the result handshake.
  - With CMD_VALID=1 on that edge, the new command is accepted as in IDLE (back-to-back, no bubble).
  - Otherwise the FSM returns to IDLE.
REQ-028 OP_COUNT SHALL increment by 1 on every completed result handshake, including illegal-opcode results, and SHALL wrap 255->0.
REQ-029 CMD_VALID while CMD_READY=0 SHALL be ignored; no command is lost or duplicated.
REQ-030 Arithmetic and width: RES_DATA SHALL be exactly R (WIDTH bits); the block SHALL perform no computation on R.

Reset
REQ-031 On an edge with RESET=1, SHALL enter IDLE and clear all registers from any state, aborting any in-flight operation without producing a result.
REQ-032 Reset values: OP=000, A=0, B=0, RES_DATA=0, RES_OP=000, RES_ERR=0, RES_VALID=0, OP_COUNT=0, counter=0.
REQ-033 CMD_READY SHALL be 0 while RESET=1 and SHALL be 1 in the first cycle after reset deasserts.
REQ-034 RESET SHALL take priority over every simultaneous handshake.

Verification (WIDTH=16, LATENCY=2, ALU model computes R from OP/A/B)
REQ-035 Reset: hold RESET for 2 cycles -> all outputs at their reset values, and CMD_READY=1 after release.
REQ-036 ADD: ADD A=0x0003 B=0x0004 -> OP=000 for 2 cycles; then RES_VALID=1, RES_DATA=0x0007, RES_OP=000, RES_ERR=0, exactly 2 cycles after accept.
REQ-037 Backpressure: SUB 0x0005-0x0007 with RES_READY=0 for 5 cycles -> RES_DATA=0xFFFE held stable, CMD_READY=0, OP_COUNT unchanged; after release, OP_COUNT=1.
REQ-038 Illegal opcode: CMD_OP=111 -> RES_VALID one cycle after accept with RES_ERR=1 and RES_DATA=0x0000; OP/A/B unchanged; OP_COUNT increments.
REQ-039 Back-to-back: CMD_VALID and RES_READY held high, issuing SLL 0x0001 by 4, then OR 0x00F0|0x000F -> results 0x0010 and 0x00FF, no idle cycle between commands, OP_COUNT=2.
REQ-040 Reset mid-operation: RESET in the second ISSUE cycle -> no RES_VALID pulse, all outputs reset, OP_COUNT=0, and the next command completes normally.

Source files
------------

// File: rtl/alu_op_issuer.sv
// alu_op_issuer: accepts one ALU command at a time, holds the operands on the
// ALU bus for LATENCY cycles, captures the ALU result and presents it with a
// valid/ready handshake. Opcode 3'b111 is reported as an error result without
// touching the ALU bus.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// S_IDLE   | no command in flight, CMD_READY high
// S_ISSUE  | OP/A/B held on the ALU bus, settle counter running down
// S_DONE   | result presented; a command may be accepted on the handshake edge

module alu_op_issuer #(
    parameter int WIDTH   = 16,
    parameter int LATENCY = 2
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [2:0]       CMD_OP,
    input  logic [WIDTH-1:0] CMD_A,
    input  logic [WIDTH-1:0] CMD_B,
    output logic [2:0]       OP,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] R,
    output logic             RES_VALID,
    input  logic             RES_READY,
    output logic [WIDTH-1:0] RES_DATA,
    output logic [2:0]       RES_OP,
    output logic             RES_ERR,
    output logic [7:0]       OP_COUNT
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [2:0] OP_ILLEGAL = 3'b111;
    localparam logic [2:0] LAT_INIT   = 3'(LATENCY);

    logic [1:0]       state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic [2:0]       res_op_q, res_op_d;
    logic             res_err_q, res_err_d;
    logic [7:0]       op_count_q, op_count_d;

    logic cmd_ready;
    logic accept;

    // Handshake qualifiers; reset masks readiness so nothing is accepted during it.
    always_comb begin
        cmd_ready = !RESET && ((state_q == S_IDLE) ||
                               ((state_q == S_DONE) && RES_READY));
        accept    = CMD_VALID && cmd_ready;
    end

    // Next-state logic: sequence the operation, then let an accept override it.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        res_data_d = res_data_q;
        res_op_d   = res_op_q;
        res_err_d  = res_err_q;
        op_count_d = op_count_q;

        case (state_q)
            S_IDLE: ;
            S_ISSUE: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    res_data_d = R;
                    res_op_d   = op_q;
                    res_err_d  = 1'b0;
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                if (RES_READY) begin
                    op_count_d = op_count_q + 8'd1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A back-to-back accept in DONE takes precedence over returning to IDLE.
        if (accept) begin
            if (CMD_OP == OP_ILLEGAL) begin
                // Illegal opcodes never reach the ALU bus; the last legal
                // operands stay driven.
                res_data_d = '0;
                res_op_d   = OP_ILLEGAL;
                res_err_d  = 1'b1;
                state_d    = S_DONE;
            end else begin
                op_d    = CMD_OP;
                a_d     = CMD_A;
                b_d     = CMD_B;
                cnt_d   = LAT_INIT;
                state_d = S_ISSUE;
            end
        end
    end

    // State registers with synchronous reset that aborts any in-flight operation.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            cnt_q      <= 3'd0;
            op_q       <= 3'd0;
            a_q        <= '0;
            b_q        <= '0;
            res_data_q <= '0;
            res_op_q   <= 3'd0;
            res_err_q  <= 1'b0;
            op_count_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            res_data_q <= res_data_d;
            res_op_q   <= res_op_d;
            res_err_q  <= res_err_d;
            op_count_q <= op_count_d;
        end
    end

    // Output drive straight from registers, except the ready path.
    always_comb begin
        CMD_READY = cmd_ready;
        OP        = op_q;
        A         = a_q;
        B         = b_q;
        RES_VALID = (state_q == S_DONE);
        RES_DATA  = res_data_q;
        RES_OP    = res_op_q;
        RES_ERR   = res_err_q;
        OP_COUNT  = op_count_q;
    end

endmodule

// File: tb/tb_alu_op_issuer.sv
// tb_alu_op_issuer: directed test of alu_op_issuer with a behavioural ALU
// computing R from OP/A/B.

module tb_alu_op_issuer;

    localparam int WIDTH   = 16;
    localparam int LATENCY = 2;

    logic             CLK = 1'b0;
    logic             RESET;
    logic             CMD_VALID;
    logic             CMD_READY;
    logic [2:0]       CMD_OP;
    logic [WIDTH-1:0] CMD_A;
    logic [WIDTH-1:0] CMD_B;
    logic [2:0]       OP;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] R;
    logic             RES_VALID;
    logic             RES_READY;
    logic [WIDTH-1:0] RES_DATA;
    logic [2:0]       RES_OP;
    logic             RES_ERR;
    logic [7:0]       OP_COUNT;

    int checks   = 0;
    int failures = 0;

    alu_op_issuer #(.WIDTH(WIDTH), .LATENCY(LATENCY)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .CMD_VALID (CMD_VALID),
        .CMD_READY (CMD_READY),
        .CMD_OP    (CMD_OP),
        .CMD_A     (CMD_A),
        .CMD_B     (CMD_B),
        .OP        (OP),
        .A         (A),
        .B         (B),
        .R         (R),
        .RES_VALID (RES_VALID),
        .RES_READY (RES_READY),
        .RES_DATA  (RES_DATA),
        .RES_OP    (RES_OP),
        .RES_ERR   (RES_ERR),
        .OP_COUNT  (OP_COUNT)
    );

    always #5 CLK = ~CLK;

    // Behavioural ALU driven by the issuer's registered bus.
    always_comb begin
        case (OP)
            3'b000:  R = A + B;
            3'b001:  R = A - B;
            3'b010:  R = 16'($signed(A) >>> B[3:0]);
            3'b011:  R = A >> B[3:0];
            3'b100:  R = A << B[3:0];
            3'b101:  R = A & B;
            3'b110:  R = A | B;
            default: R = '0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        tick();
        tick();
        RESET = 1'b0;
    endtask

    task automatic put_cmd(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        CMD_VALID = 1'b1;
        CMD_OP    = op;
        CMD_A     = a;
        CMD_B     = b;
    endtask

    initial begin
        RESET     = 1'b1;
        CMD_VALID = 1'b0;
        CMD_OP    = 3'b000;
        CMD_A     = '0;
        CMD_B     = '0;
        RES_READY = 1'b0;

        // Reset values, held for two cycles.
        tick();
        tick();
        chk("rst_cmd_ready_low", 32'(CMD_READY), 32'd0);
        chk("rst_res_valid",     32'(RES_VALID), 32'd0);
        chk("rst_op",            32'(OP),        32'd0);
        chk("rst_a",             32'(A),         32'd0);
        chk("rst_b",             32'(B),         32'd0);
        chk("rst_res_data",      32'(RES_DATA),  32'd0);
        chk("rst_res_op",        32'(RES_OP),    32'd0);
        chk("rst_res_err",       32'(RES_ERR),   32'd0);
        chk("rst_op_count",      32'(OP_COUNT),  32'd0);
        RESET = 1'b0;
        #1;
        chk("rst_cmd_ready_rel", 32'(CMD_READY), 32'd1);

        // ADD 3+4, result exactly LATENCY cycles after accept.
        put_cmd(3'b000, 16'h0003, 16'h0004);
        tick();
        CMD_VALID = 1'b0;
        chk("add_op_c1",       32'(OP),        32'd0);
        chk("add_a",           32'(A),         32'h3);
        chk("add_b",           32'(B),         32'h4);
        chk("add_busy",        32'(CMD_READY), 32'd0);
        chk("add_valid_c1",    32'(RES_VALID), 32'd0);
        tick();
        chk("add_op_c2",       32'(OP),        32'd0);
        chk("add_valid_c2",    32'(RES_VALID), 32'd0);
        tick();
        chk("add_valid",       32'(RES_VALID), 32'd1);
        chk("add_data",        32'(RES_DATA),  32'h0007);
        chk("add_res_op",      32'(RES_OP),    32'd0);
        chk("add_err",         32'(RES_ERR),   32'd0);
        RES_READY = 1'b1;
        tick();
        chk("add_count",       32'(OP_COUNT),  32'd1);
        chk("add_valid_after", 32'(RES_VALID), 32'd0);

        // SUB with 5 cycles of backpressure; an offered command must be ignored.
        do_reset();
        RES_READY = 1'b0;
        put_cmd(3'b001, 16'h0005, 16'h0007);
        tick();
        put_cmd(3'b000, 16'h1111, 16'h2222);
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid",     32'(RES_VALID), 32'd1);
            chk("bp_data",      32'(RES_DATA),  32'hFFFE);
            chk("bp_cmd_ready", 32'(CMD_READY), 32'd0);
            chk("bp_count",     32'(OP_COUNT),  32'd0);
            chk("bp_op_held",   32'(OP),        32'd1);
            tick();
        end
        CMD_VALID = 1'b0;
        RES_READY = 1'b1;
        #1;
        chk("bp_cmd_ready_rel", 32'(CMD_READY), 32'd1);
        tick();
        chk("bp_count_rel",     32'(OP_COUNT),  32'd1);
        chk("bp_valid_rel",     32'(RES_VALID), 32'd0);

        // Illegal opcode: one-cycle error result, ALU bus untouched.
        RES_READY = 1'b0;
        put_cmd(3'b111, 16'hAAAA, 16'h5555);
        tick();
        CMD_VALID = 1'b0;
        chk("ill_valid",  32'(RES_VALID), 32'd1);
        chk("ill_err",    32'(RES_ERR),   32'd1);
        chk("ill_data",   32'(RES_DATA),  32'h0000);
        chk("ill_res_op", 32'(RES_OP),    32'd7);
        chk("ill_op",     32'(OP),        32'd1);
        chk("ill_a",      32'(A),         32'h0005);
        chk("ill_b",      32'(B),         32'h0007);
        RES_READY = 1'b1;
        tick();
        chk("ill_count",  32'(OP_COUNT),  32'd2);

        // Back-to-back SLL then OR with CMD_VALID/RES_READY held high.
        do_reset();
        RES_READY = 1'b1;
        put_cmd(3'b100, 16'h0001, 16'h0004);
        tick();
        put_cmd(3'b110, 16'h00F0, 16'h000F);
        chk("b2b_busy",      32'(CMD_READY), 32'd0);
        chk("b2b_op1",       32'(OP),        32'd4);
        tick();
        tick();
        chk("b2b_valid1",    32'(RES_VALID), 32'd1);
        chk("b2b_data1",     32'(RES_DATA),  32'h0010);
        chk("b2b_res_op1",   32'(RES_OP),    32'd4);
        chk("b2b_ready_dn",  32'(CMD_READY), 32'd1);
        tick();
        chk("b2b_op2",       32'(OP),        32'd6);
        chk("b2b_a2",        32'(A),         32'h00F0);
        chk("b2b_count1",    32'(OP_COUNT),  32'd1);
        chk("b2b_valid_gap", 32'(RES_VALID), 32'd0);
        tick();
        tick();
        CMD_VALID = 1'b0;
        chk("b2b_valid2",    32'(RES_VALID), 32'd1);
        chk("b2b_data2",     32'(RES_DATA),  32'h00FF);
        tick();
        chk("b2b_count2",    32'(OP_COUNT),  32'd2);
        chk("b2b_idle",      32'(RES_VALID), 32'd0);

        // Reset in the second ISSUE cycle aborts the operation.
        RES_READY = 1'b1;
        put_cmd(3'b000, 16'h0001, 16'h0001);
        tick();
        CMD_VALID = 1'b0;
        tick();
        RESET = 1'b1;
        tick();
        chk("mid_valid",     32'(RES_VALID), 32'd0);
        chk("mid_data",      32'(RES_DATA),  32'd0);
        chk("mid_op",        32'(OP),        32'd0);
        chk("mid_a",         32'(A),         32'd0);
        chk("mid_count",     32'(OP_COUNT),  32'd0);
        chk("mid_cmd_ready", 32'(CMD_READY), 32'd0);
        tick();
        chk("mid_valid2",    32'(RES_VALID), 32'd0);
        RESET = 1'b0;
        put_cmd(3'b101, 16'hFF0F, 16'h0FF0);
        tick();
        CMD_VALID = 1'b0;
        tick();
        tick();
        chk("mid_next_valid", 32'(RES_VALID), 32'd1);
        chk("mid_next_data",  32'(RES_DATA),  32'h0F00);
        tick();
        chk("mid_next_count", 32'(OP_COUNT),  32'd1);

        // SRA of a negative operand, then reset beating a simultaneous handshake.
        RES_READY = 1'b0;
        put_cmd(3'b010, 16'h8000, 16'h0003);
        tick();
        CMD_VALID = 1'b0;
        tick();
        tick();
        chk("sra_data",  32'(RES_DATA), 32'hF000);
        RES_READY = 1'b1;
        put_cmd(3'b011, 16'h8000, 16'h0003);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        CMD_VALID = 1'b0;
        chk("prio_count", 32'(OP_COUNT),  32'd0);
        chk("prio_valid", 32'(RES_VALID), 32'd0);
        chk("prio_op",    32'(OP),        32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
